// File: rtl/ysyx_25040109_dmem_responder_if.sv
// Data-memory request/response channel between the load/store unit and the
// memory responder.
//   req_valid/req_ready : request handshake
//   req_addr            : byte address
//   req_wen             : 1 = store, 0 = load
//   req_size            : 0 byte, 1 half, 2 word, 3 illegal
//   req_wdata           : store data, right-justified
//   rsp_valid/rsp_ready : response handshake
//   rsp_rdata           : load data, right-justified (0 for stores/errors)
//   rsp_err             : access fault
interface ysyx_25040109_dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_wen;
  logic [1:0]  req_size;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_addr, req_wen, req_size, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, req_wen, req_size, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/ysyx_25040109_dmem_responder.sv
// Memory-side responder for the load/store path. Accepts one request at a
// time, performs a byte/half/word access on an internal word array after
// LATENCY cycles and returns the result on the response channel.
// Ports:
//   i_clock  : clock, all logic on the rising edge
//   i_reset  : synchronous active-high reset
//   io_dmem  : request/response channel (slave side)
//
// state  | meaning
// S_IDLE | ready to accept a request
// S_BUSY | latency counter running
// S_RESP | response presented, waiting for rsp_ready
module ysyx_25040109_dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned LATENCY     = 2
) (
  input  logic                             i_clock,
  input  logic                             i_reset,
  ysyx_25040109_dmem_responder_if.slave    io_dmem
);

  localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_RESP
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_addr;
  logic             r_wen;
  logic [1:0]       r_size;
  logic [31:0]      r_wdata;
  logic             r_rsp_valid;
  logic [31:0]      r_rsp_rdata;
  logic             r_rsp_err;

  logic [31:0]      r_mem [DEPTH_WORDS];

  logic             w_req_ready;
  logic             w_accept;
  logic             w_complete;
  logic [1:0]       w_off;
  logic [29:0]      w_idx_full;
  logic [IDX_W-1:0] w_idx;
  logic             w_below;
  logic             w_beyond;
  logic             w_misalign;
  logic             w_err;
  logic [3:0]       w_strb_base;
  logic [3:0]       w_strb;
  logic [31:0]      w_wdata_sh;
  logic [31:0]      w_word;
  logic [31:0]      w_rdata_sh;
  logic             w_mem_we;

  assign w_req_ready = (r_state == S_IDLE) && !i_reset;
  assign w_accept    = io_dmem.req_valid && w_req_ready;
  // Counter is loaded with LATENCY-1 at acceptance; the access completes on
  // the edge where it reads zero, giving rsp_valid exactly LATENCY edges later.
  assign w_complete  = (r_state == S_BUSY) && (r_cnt == '0);

  assign w_off      = r_addr[1:0];
  // BASE_ADDR is word aligned, so the index can be formed from the word bits.
  assign w_idx_full = r_addr[31:2] - BASE_ADDR[31:2];
  assign w_idx      = w_idx_full[IDX_W-1:0];
  assign w_below    = r_addr < BASE_ADDR;
  assign w_beyond   = w_idx_full >= 30'(DEPTH_WORDS);

  always_comb begin
    w_misalign  = 1'b0;
    w_strb_base = 4'b0000;
    case (r_size)
      2'd0: w_strb_base = 4'b0001;
      2'd1: begin
        w_strb_base = 4'b0011;
        w_misalign  = r_addr[0];
      end
      2'd2: begin
        w_strb_base = 4'b1111;
        w_misalign  = (r_addr[1:0] != 2'b00);
      end
      default: w_misalign = 1'b1;
    endcase
  end

  assign w_err      = w_misalign || w_below || w_beyond;
  assign w_strb     = w_strb_base << w_off;
  assign w_wdata_sh = r_wdata << {w_off, 3'b000};
  assign w_word     = r_mem[w_idx];
  assign w_rdata_sh = w_word >> {w_off, 3'b000};
  // Reset on the completion edge suppresses the write.
  assign w_mem_we   = w_complete && r_wen && !w_err && !i_reset;

  always_ff @(posedge i_clock) begin
    if (w_mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (w_strb[b]) begin
          r_mem[w_idx][8*b +: 8] <= w_wdata_sh[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_addr      <= '0;
      r_wen       <= 1'b0;
      r_size      <= 2'd0;
      r_wdata     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_addr  <= io_dmem.req_addr;
            r_wen   <= io_dmem.req_wen;
            r_size  <= io_dmem.req_size;
            r_wdata <= io_dmem.req_wdata;
            r_cnt   <= CNT_INIT;
            r_state <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (w_complete) begin
            r_state     <= S_RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= w_err;
            r_rsp_rdata <= (w_err || r_wen) ? 32'd0 : w_rdata_sh;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_RESP: begin
          if (io_dmem.rsp_ready) begin
            r_state     <= S_IDLE;
            r_rsp_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  assign io_dmem.req_ready = w_req_ready;
  assign io_dmem.rsp_valid = r_rsp_valid;
  assign io_dmem.rsp_rdata = r_rsp_rdata;
  assign io_dmem.rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_ysyx_25040109_dmem_responder.sv
module tb_ysyx_25040109_dmem_responder;
  localparam int LAT_A = 2;
  localparam int LAT_B = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int last_acc_a = 0;

  ysyx_25040109_dmem_responder_if ifa ();
  ysyx_25040109_dmem_responder_if ifb ();

  ysyx_25040109_dmem_responder #(.LATENCY(LAT_A)) dut_a (
    .i_clock (clk),
    .i_reset (rst),
    .io_dmem (ifa)
  );

  ysyx_25040109_dmem_responder #(.LATENCY(LAT_B)) dut_b (
    .i_clock (clk),
    .i_reset (rst),
    .io_dmem (ifb)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic        wen;
    logic [1:0]  size;
    logic [31:0] wdata;
    logic [31:0] rd;
    logic        err;
  } vec_t;

  exp_t q_a[$];
  exp_t q_b[$];
  vec_t vb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic to_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout required event", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // ---------------- monitors ----------------
  logic in_a = 1'b0;
  exp_t cur_a;
  always @(negedge clk) begin
    if (rst) begin
      in_a = 1'b0;
    end else if (ifa.rsp_valid) begin
      if (!in_a) begin
        in_a = 1'b1;
        if (q_a.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL a_unexpected_rsp: got rsp_valid=1 required 0");
          cur_a.rdata = ifa.rsp_rdata;
          cur_a.err   = ifa.rsp_err;
        end else begin
          cur_a = q_a.pop_front();
          chk("a_latency", cyc, cur_a.acc + LAT_A);
          chk("a_rdata", ifa.rsp_rdata, cur_a.rdata);
          chk("a_err", {31'd0, ifa.rsp_err}, {31'd0, cur_a.err});
        end
      end else begin
        chk("a_hold_rdata", ifa.rsp_rdata, cur_a.rdata);
        chk("a_hold_err", {31'd0, ifa.rsp_err}, {31'd0, cur_a.err});
        chk("a_req_ready_in_resp", {31'd0, ifa.req_ready}, 32'd0);
      end
      if (ifa.rsp_ready) in_a = 1'b0;
    end
  end

  logic in_b = 1'b0;
  exp_t cur_b;
  always @(negedge clk) begin
    if (rst) begin
      in_b = 1'b0;
    end else if (ifb.rsp_valid) begin
      if (!in_b) begin
        in_b = 1'b1;
        if (q_b.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL b_unexpected_rsp: got rsp_valid=1 required 0");
        end else begin
          cur_b = q_b.pop_front();
          chk("b_latency", cyc, cur_b.acc + LAT_B);
          chk("b_rdata", ifb.rsp_rdata, cur_b.rdata);
          chk("b_err", {31'd0, ifb.rsp_err}, {31'd0, cur_b.err});
        end
      end
      if (ifb.rsp_ready) in_b = 1'b0;
    end
  end

  // ---------------- drivers ----------------
  task automatic send_a(input logic [31:0] addr, input logic wen, input logic [1:0] size,
                        input logic [31:0] wdata, input logic [31:0] erd, input logic eerr);
    int n;
    exp_t e;
    ifa.req_valid = 1'b1;
    ifa.req_addr  = addr;
    ifa.req_wen   = wen;
    ifa.req_size  = size;
    ifa.req_wdata = wdata;
    n = 0;
    while (!ifa.req_ready && n < 50) begin
      tick();
      n++;
    end
    if (!ifa.req_ready) begin
      to_fail("a_req_ready_wait");
      ifa.req_valid = 1'b0;
      return;
    end
    last_acc_a = cyc + 1;
    e.rdata = erd;
    e.err   = eerr;
    e.acc   = last_acc_a;
    q_a.push_back(e);
    tick();
    // Inputs are ignored after acceptance; scramble them.
    ifa.req_valid = 1'b0;
    ifa.req_addr  = $urandom();
    ifa.req_wdata = $urandom();
    ifa.req_size  = 2'($urandom_range(0, 3));
  endtask

  task automatic drain_a();
    int n = 0;
    while ((q_a.size() != 0 || ifa.rsp_valid) && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) to_fail("a_drain");
  endtask

  task automatic drain_b();
    int n = 0;
    while ((q_b.size() != 0 || ifb.rsp_valid) && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) to_fail("b_drain");
  endtask

  task automatic addv(input logic [31:0] a, input logic w, input logic [1:0] s,
                      input logic [31:0] d, input logic [31:0] r, input logic e);
    vec_t v;
    v.addr = a; v.wen = w; v.size = s; v.wdata = d; v.rd = r; v.err = e;
    vb.push_back(v);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish required finish");
    $fatal(1);
  end

  initial begin
    int n;
    int hs;
    int prev;
    exp_t e;

    ifa.req_valid = 1'b0; ifa.req_addr = '0; ifa.req_wen = 1'b0;
    ifa.req_size = 2'd0; ifa.req_wdata = '0; ifa.rsp_ready = 1'b1;
    ifb.req_valid = 1'b0; ifb.req_addr = '0; ifb.req_wen = 1'b0;
    ifb.req_size = 2'd0; ifb.req_wdata = '0; ifb.rsp_ready = 1'b1;

    // Reset values
    rst = 1'b1;
    repeat (3) tick();
    chk("a_rst_req_ready", {31'd0, ifa.req_ready}, 32'd0);
    chk("a_rst_rsp_valid", {31'd0, ifa.rsp_valid}, 32'd0);
    chk("a_rst_rdata", ifa.rsp_rdata, 32'd0);
    chk("a_rst_err", {31'd0, ifa.rsp_err}, 32'd0);
    chk("b_rst_req_ready", {31'd0, ifb.req_ready}, 32'd0);
    chk("b_rst_rsp_valid", {31'd0, ifb.rsp_valid}, 32'd0);
    rst = 1'b0;
    #1;
    chk("a_ready_after_reset", {31'd0, ifa.req_ready}, 32'd1);
    chk("b_ready_after_reset", {31'd0, ifb.req_ready}, 32'd1);
    tick();

    // Word store / load
    send_a(32'h8000_0010, 1'b1, 2'd2, 32'hDEAD_BEEF, 32'h0, 1'b0);
    send_a(32'h8000_0010, 1'b0, 2'd2, 32'h0,         32'hDEAD_BEEF, 1'b0);

    // Byte lanes; upper wdata bits must not leak past the strobe
    send_a(32'h8000_0020, 1'b1, 2'd2, 32'h1122_3344, 32'h0, 1'b0);
    send_a(32'h8000_0022, 1'b1, 2'd0, 32'h1234_56AB, 32'h0, 1'b0);
    send_a(32'h8000_0020, 1'b0, 2'd2, 32'h0, 32'h11AB_3344, 1'b0);
    send_a(32'h8000_0023, 1'b0, 2'd0, 32'h0, 32'h0000_0011, 1'b0);
    send_a(32'h8000_0022, 1'b0, 2'd1, 32'h0, 32'h0000_11AB, 1'b0);

    // Faults leave memory unchanged
    send_a(32'h8000_0000, 1'b1, 2'd2, 32'hCAFE_F00D, 32'h0, 1'b0);
    send_a(32'h8000_0FFC, 1'b1, 2'd2, 32'h0BAD_C0DE, 32'h0, 1'b0);
    send_a(32'h8000_0001, 1'b1, 2'd1, 32'hFFFF_FFFF, 32'h0, 1'b1);
    send_a(32'h8000_0001, 1'b0, 2'd1, 32'h0,         32'h0, 1'b1);
    send_a(32'h8000_0002, 1'b1, 2'd2, 32'hFFFF_FFFF, 32'h0, 1'b1);
    send_a(32'h7FFF_FFFC, 1'b1, 2'd2, 32'hFFFF_FFFF, 32'h0, 1'b1);
    send_a(32'h7FFF_FFFC, 1'b0, 2'd2, 32'h0,         32'h0, 1'b1);
    send_a(32'h8000_1000, 1'b1, 2'd2, 32'hFFFF_FFFF, 32'h0, 1'b1);
    send_a(32'h8000_0000, 1'b1, 2'd3, 32'hFFFF_FFFF, 32'h0, 1'b1);
    send_a(32'h8000_0000, 1'b0, 2'd2, 32'h0, 32'hCAFE_F00D, 1'b0);
    send_a(32'h8000_0FFC, 1'b0, 2'd2, 32'h0, 32'h0BAD_C0DE, 1'b0);
    send_a(32'h8000_0FFF, 1'b0, 2'd0, 32'h0, 32'h0000_000B, 1'b0);
    drain_a();

    // Response backpressure
    ifa.rsp_ready = 1'b0;
    send_a(32'h8000_0010, 1'b0, 2'd2, 32'h0, 32'hDEAD_BEEF, 1'b0);
    n = 0;
    while (!ifa.rsp_valid && n < 20) begin
      tick();
      n++;
    end
    if (!ifa.rsp_valid) to_fail("a_bp_valid");
    repeat (5) tick();
    chk("a_bp_valid_held", {31'd0, ifa.rsp_valid}, 32'd1);
    hs = cyc + 1;
    ifa.rsp_ready = 1'b1;
    send_a(32'h8000_0020, 1'b0, 2'd2, 32'h0, 32'h11AB_3344, 1'b0);
    chk("a_accept_after_handshake", last_acc_a, hs + 1);
    drain_a();

    // Reset mid-flight; reset lands on the completion edge
    send_a(32'h8000_0040, 1'b1, 2'd2, 32'h1234_5678, 32'h0, 1'b0);
    drain_a();
    send_a(32'h8000_0040, 1'b1, 2'd2, 32'h0000_00FF, 32'h0, 1'b0);
    e = q_a.pop_back();
    tick();
    rst = 1'b1;
    tick();
    tick();
    chk("a_no_rsp_in_reset", {31'd0, ifa.rsp_valid}, 32'd0);
    rst = 1'b0;
    #1;
    chk("a_ready_after_midflight_reset", {31'd0, ifa.req_ready}, 32'd1);
    repeat (4) tick();
    send_a(32'h8000_0040, 1'b0, 2'd2, 32'h0, 32'h1234_5678, 1'b0);
    drain_a();

    // LATENCY=1 instance, request held continuously.
    // Each request walks IDLE -> BUSY -> RESP -> handshake -> IDLE.
    addv(32'h8000_0100, 1'b1, 2'd2, 32'hA5A5_0001, 32'h0, 1'b0);
    addv(32'h8000_0101, 1'b1, 2'd0, 32'hFFFF_FF77, 32'h0, 1'b0);
    addv(32'h8000_0106, 1'b1, 2'd1, 32'h0000_BEEF, 32'h0, 1'b0);
    addv(32'h8000_0100, 1'b0, 2'd2, 32'h0, 32'hA5A5_7701, 1'b0);
    addv(32'h8000_0101, 1'b0, 2'd0, 32'h0, 32'h00A5_A577, 1'b0);
    addv(32'h8000_0106, 1'b0, 2'd1, 32'h0, 32'h0000_BEEF, 1'b0);
    addv(32'h8000_0103, 1'b0, 2'd1, 32'h0, 32'h0, 1'b1);
    addv(32'h8000_0103, 1'b0, 2'd0, 32'h0, 32'h0000_00A5, 1'b0);
    prev = 0;
    foreach (vb[i]) begin
      ifb.req_valid = 1'b1;
      ifb.req_addr  = vb[i].addr;
      ifb.req_wen   = vb[i].wen;
      ifb.req_size  = vb[i].size;
      ifb.req_wdata = vb[i].wdata;
      n = 0;
      while (!ifb.req_ready && n < 50) begin
        tick();
        n++;
      end
      if (!ifb.req_ready) begin
        to_fail("b_req_ready_wait");
      end else begin
        e.rdata = vb[i].rd;
        e.err   = vb[i].err;
        e.acc   = cyc + 1;
        q_b.push_back(e);
        if (i > 0) chk("b_accept_interval", e.acc - prev, LAT_B + 2);
        prev = e.acc;
        tick();
      end
    end
    ifb.req_valid = 1'b0;
    drain_b();
    drain_a();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
